// File: rtl/mac_engine_vec_if.sv
`default_nettype none
// ============================================================================
// Module   : mac_engine_vec_if
// Purpose  : Bundles the A/B operand streams and the D result stream of the
//            vectorised MAC engine into one port.
// Ports    : a_valid/a_data/a_ready - A operand stream (lane k at [k*DW +: DW])
//            b_valid/b_data/b_ready - B operand stream, same layout as A
//            d_valid/d_data/d_ready - result stream, same layout as A
//            modport master : producer of operands / consumer of results
//            modport slave  : the engine side
// Revision : 1.0 - initial release
// ============================================================================
interface mac_engine_vec_if #(
  parameter int N_LANES    = 4,
  parameter int DATA_WIDTH = 32
);
  logic                          a_valid;
  logic [N_LANES*DATA_WIDTH-1:0] a_data;
  logic                          a_ready;
  logic                          b_valid;
  logic [N_LANES*DATA_WIDTH-1:0] b_data;
  logic                          b_ready;
  logic                          d_valid;
  logic [N_LANES*DATA_WIDTH-1:0] d_data;
  logic                          d_ready;

  modport master (
    output a_valid, a_data, b_valid, b_data, d_ready,
    input  a_ready, b_ready, d_valid, d_data
  );

  modport slave (
    input  a_valid, a_data, b_valid, b_data, d_ready,
    output a_ready, b_ready, d_valid, d_data
  );
endinterface
`default_nettype wire

// File: rtl/mac_engine_vec.sv
`default_nettype none
// ============================================================================
// Module   : mac_engine_vec
// Purpose  : N-lane multiply / multiply-accumulate engine. Consumes paired A/B
//            beats, multiplies per lane, and either emits every product
//            (SIMPLE) or accumulates LEN beats into one result beat (ACCUM).
//            Results are arithmetically right-shifted, then truncated or
//            saturated to DATA_WIDTH.
// Ports    : clk_i, rst_ni (sync, active-low), clear_i (sync abort)
//            start_i/len_i/accum_i/shift_i - job configuration, taken on start
//            strm   - A/B operand streams and D result stream (slave modport)
//            busy_o - job in progress, done_o - one-cycle end-of-job pulse
//            cnt_o  - beats consumed in the current job
// Config   : define MAC_ENGINE_VEC_SAT_EN to saturate results to the signed
//            DATA_WIDTH range instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module mac_engine_vec #(
  parameter  int N_LANES    = 4,
  parameter  int DATA_WIDTH = 32,
  parameter  int ACC_EXTRA  = 8,
  parameter  int LEN_WIDTH  = 16,
  localparam int ACC_W      = 2*DATA_WIDTH + ACC_EXTRA,
  localparam int SHIFT_W    = $clog2(ACC_W)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 start_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  input  logic                 accum_i,
  input  logic [SHIFT_W-1:0]   shift_i,
  mac_engine_vec_if.slave      strm,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [LEN_WIDTH-1:0] cnt_o
);

  localparam int PROD_W = 2*DATA_WIDTH;
  localparam int BUS_W  = N_LANES*DATA_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [LEN_WIDTH-1:0]     len_q, len_d;
  logic [LEN_WIDTH-1:0]     cnt_q, cnt_d;
  logic                     accum_q, accum_d;
  logic [SHIFT_W-1:0]       shift_q, shift_d;
  logic                     s1_valid_q, s1_valid_d;
  logic                     s1_last_q, s1_last_d;
  logic signed [PROD_W-1:0] prod_q [N_LANES];
  logic signed [PROD_W-1:0] prod_d [N_LANES];
  logic signed [ACC_W-1:0]  acc_q  [N_LANES];
  logic signed [ACC_W-1:0]  acc_d  [N_LANES];
  logic                     out_valid_q, out_valid_d;
  logic                     out_last_q, out_last_d;
  logic [BUS_W-1:0]         out_data_q, out_data_d;
  logic                     done_q, done_d;

  logic signed [PROD_W-1:0] prod_w  [N_LANES];
  logic signed [ACC_W-1:0]  acc_sum [N_LANES];
  logic [DATA_WIDTH-1:0]    res     [N_LANES];

  logic                     adv;
  logic                     fire;
  logic                     last_beat;
  logic [LEN_WIDTH-1:0]     cnt_inc;

  // --------------------------------------------------------------------------
  // Per-lane datapath: multiply, accumulate, shift, narrow
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    logic signed [DATA_WIDTH-1:0] a_l, b_l;
    logic signed [PROD_W-1:0]     a_x, b_x;
    logic signed [ACC_W-1:0]      prod_ext;
    logic signed [ACC_W-1:0]      pre_shift;
    logic signed [ACC_W-1:0]      shifted;

    assign a_l = strm.a_data[k*DATA_WIDTH +: DATA_WIDTH];
    assign b_l = strm.b_data[k*DATA_WIDTH +: DATA_WIDTH];
    // Operands widened first so the low 2*DW bits hold the exact signed product.
    assign a_x = {{DATA_WIDTH{a_l[DATA_WIDTH-1]}}, a_l};
    assign b_x = {{DATA_WIDTH{b_l[DATA_WIDTH-1]}}, b_l};
    assign prod_w[k] = a_x * b_x;

    assign prod_ext   = {{ACC_EXTRA{prod_q[k][PROD_W-1]}}, prod_q[k]};
    assign acc_sum[k] = acc_q[k] + prod_ext;
    // In ACCUM mode the emitted value includes the beat entering stage 2 now.
    assign pre_shift  = accum_q ? acc_sum[k] : prod_ext;
    assign shifted    = pre_shift >>> shift_q;

`ifdef MAC_ENGINE_VEC_SAT_EN
    localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    logic ovf;
    // Representable iff every bit from DW-1 upward is a copy of the sign.
    assign ovf    = shifted[ACC_W-1:DATA_WIDTH-1] !=
                    {(ACC_W-DATA_WIDTH+1){shifted[ACC_W-1]}};
    assign res[k] = ovf ? (shifted[ACC_W-1] ? SAT_MIN : SAT_MAX)
                        : shifted[DATA_WIDTH-1:0];
`else
    logic unused_hi;
    assign unused_hi = ^shifted[ACC_W-1:DATA_WIDTH];
    assign res[k]    = shifted[DATA_WIDTH-1:0];
`endif
  end

  // --------------------------------------------------------------------------
  // Handshake: both streams are taken together, only when stage 2 can move.
  // --------------------------------------------------------------------------
  assign adv       = !out_valid_q || strm.d_ready;
  assign fire      = (state_q == ST_RUN) && strm.a_valid && strm.b_valid && adv;
  assign cnt_inc   = cnt_q + {{(LEN_WIDTH-1){1'b0}}, 1'b1};
  assign last_beat = fire && (cnt_inc == len_q);

  assign strm.a_ready = fire;
  assign strm.b_ready = fire;
  assign strm.d_valid = out_valid_q;
  assign strm.d_data  = out_data_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = done_q;
  assign cnt_o        = cnt_q;

  // --------------------------------------------------------------------------
  // Next-state, pipeline and control
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    accum_d     = accum_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    s1_valid_d  = s1_valid_q;
    s1_last_d   = s1_last_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    done_d      = 1'b0;
    for (int k = 0; k < N_LANES; k++) begin
      prod_d[k] = prod_q[k];
      acc_d[k]  = acc_q[k];
    end

    // Whole pipe moves as one; it only stalls on an unaccepted result.
    if (adv) begin
      s1_valid_d  = fire;
      s1_last_d   = last_beat;
      out_valid_d = s1_valid_q && (!accum_q || s1_last_q);
      out_last_d  = s1_last_q;
      for (int k = 0; k < N_LANES; k++) begin
        if (fire) begin
          prod_d[k] = prod_w[k];
        end
        if (s1_valid_q && accum_q) begin
          acc_d[k] = acc_sum[k];
        end
        if (s1_valid_q && (!accum_q || s1_last_q)) begin
          out_data_d[k*DATA_WIDTH +: DATA_WIDTH] = res[k];
        end
      end
    end

    if (fire) begin
      cnt_d = cnt_inc;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          cnt_d = '0;
          if (len_i != '0) begin
            state_d = ST_RUN;
            len_d   = len_i;
            accum_d = accum_i;
            shift_d = shift_i;
            for (int k = 0; k < N_LANES; k++) begin
              acc_d[k] = '0;
            end
          end else begin
            // Empty job: nothing to consume, just acknowledge.
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (last_beat) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (out_valid_q && strm.d_ready && out_last_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort takes priority over everything, including a same-cycle start.
    if (clear_i) begin
      state_d     = ST_IDLE;
      s1_valid_d  = 1'b0;
      s1_last_d   = 1'b0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      cnt_d       = '0;
      done_d      = 1'b0;
      for (int k = 0; k < N_LANES; k++) begin
        acc_d[k] = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      accum_q     <= 1'b0;
      shift_q     <= '0;
      cnt_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
      for (int k = 0; k < N_LANES; k++) begin
        prod_q[k] <= '0;
        acc_q[k]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      accum_q     <= accum_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
      for (int k = 0; k < N_LANES; k++) begin
        prod_q[k] <= prod_d[k];
        acc_q[k]  <= acc_d[k];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mac_engine_vec.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_engine_vec
// Purpose  : Self-checking bench for mac_engine_vec: table of directed jobs
//            plus hand sequences for backpressure, empty job and abort.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_engine_vec;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int LW = 16;
  localparam int SW = 7;
  localparam int BW = N*DW;

  typedef struct {
    bit             accum;
    int             len;
    int             shift;
    logic [BW-1:0]  a;
    logic [BW-1:0]  b;
    logic [BW-1:0]  exp;
  } vec_t;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          start = 1'b0;
  logic          accum = 1'b0;
  logic [LW-1:0] len   = '0;
  logic [SW-1:0] shift = '0;
  logic          busy, done;
  logic [LW-1:0] cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [BW-1:0] outq[$];
  int            out_cyc[$];
  int            acc_cyc[$];
  int            done_cyc[$];

  logic          prev_stall = 1'b0;
  logic [BW-1:0] prev_data  = '0;

  mac_engine_vec_if #(.N_LANES(N), .DATA_WIDTH(DW)) bus ();

  mac_engine_vec #(
    .N_LANES(N), .DATA_WIDTH(DW), .ACC_EXTRA(8), .LEN_WIDTH(LW)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clear_i (clear),
    .start_i (start),
    .len_i   (len),
    .accum_i (accum),
    .shift_i (shift),
    .strm    (bus),
    .busy_o  (busy),
    .done_o  (done),
    .cnt_o   (cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] pack4(input int l0, input int l1, input int l2, input int l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic vec_t mk(input bit ac, input int ln, input int sh,
                              input logic [BW-1:0] a, input logic [BW-1:0] b,
                              input logic [BW-1:0] e);
    vec_t v;
    v.accum = ac; v.len = ln; v.shift = sh; v.a = a; v.b = b; v.exp = e;
    return v;
  endfunction

  // Observe handshakes and stream rules on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.d_valid && bus.d_ready) begin
        outq.push_back(bus.d_data);
        out_cyc.push_back(cyc);
      end
      if (bus.a_ready) acc_cyc.push_back(cyc);
      if (done) done_cyc.push_back(cyc);
      if (prev_stall) begin
        chk("stall_valid", {127'd0, bus.d_valid}, 1);
        chk("stall_data", bus.d_data, prev_data);
      end
      if (bus.d_valid && !bus.d_ready)
        chk("stall_ready", {126'd0, bus.a_ready, bus.b_ready}, 0);
      if (bus.a_ready || bus.b_ready)
        chk("joint_hs", {124'd0, bus.a_valid, bus.b_valid, bus.a_ready, bus.b_ready}, 15);
      prev_stall = bus.d_valid && !bus.d_ready && !clear;
      prev_data  = bus.d_data;
    end
  end

  task automatic drive_beat(input vec_t v, input bit vary, input int k);
    if (vary) begin
      bus.a_data = pack4(k+1, -(k+1), 2, k);
      bus.b_data = pack4(1, 1, k+1, 3);
    end else begin
      bus.a_data = v.a;
      bus.b_data = v.b;
    end
  endtask

  task automatic clear_logs();
    outq.delete(); out_cyc.delete(); acc_cyc.delete(); done_cyc.delete();
  endtask

  task automatic run_job(input vec_t v, input bit bp, input bit vary, input string tag);
    int guard;
    int beats;
    logic [BW-1:0] e;
    clear_logs();
    len   = LW'(v.len);
    accum = v.accum;
    shift = SW'(v.shift);
    start = 1'b1;
    drive_beat(v, vary, 0);
    bus.a_valid = 1'b1;
    bus.b_valid = 1'b1;
    bus.d_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy"}, {127'd0, busy}, 1);
    guard = 0;
    while (done_cyc.size() == 0 && guard < 300) begin
      if (acc_cyc.size() >= v.len) begin
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
      end else begin
        drive_beat(v, vary, acc_cyc.size());
      end
      if (bp) bus.d_ready = ~bus.d_ready;
      @(posedge clk); #1;
      guard++;
    end
    bus.d_ready = 1'b1;
    chk({tag, "_timeout"}, (guard < 300) ? 1 : 0, 1);
    beats = v.accum ? 1 : v.len;
    chk({tag, "_nbeats"}, outq.size(), beats);
    for (int i = 0; i < outq.size() && i < beats; i++) begin
      e = vary ? pack4(i+1, -(i+1), 2*(i+1), 3*i) : v.exp;
      chk($sformatf("%s_data%0d", tag, i), outq[i], e);
    end
    chk({tag, "_cnt"}, cnt, v.len);
    chk({tag, "_idle"}, {127'd0, busy}, 0);
    chk({tag, "_done_pulse"}, {127'd0, done}, 0);
    if (out_cyc.size() > 0 && done_cyc.size() > 0)
      chk({tag, "_done_lat"}, done_cyc[0] - out_cyc[out_cyc.size()-1], 1);
    if (!v.accum && !bp && out_cyc.size() > 0 && acc_cyc.size() >= v.len) begin
      chk({tag, "_latency"}, out_cyc[0] - acc_cyc[0], 2);
      chk({tag, "_thru"}, acc_cyc[v.len-1] - acc_cyc[0], v.len - 1);
    end
  endtask

  vec_t vecs[6];
  vec_t v;
  int   g;

  initial begin
    bus.a_valid = 1'b1;
    bus.b_valid = 1'b1;
    bus.a_data  = '1;
    bus.b_data  = '1;
    bus.d_ready = 1'b1;

    vecs[0] = mk(0, 3, 0, pack4(2, -3, 7, 0), pack4(5, 4, -1, 9), pack4(10, -12, -7, 0));
    vecs[1] = mk(1, 4, 2, pack4(3, 3, 3, 3), pack4(3, 3, 3, 3), pack4(9, 9, 9, 9));
`ifdef MAC_ENGINE_VEC_SAT_EN
    vecs[2] = mk(1, 1, 0, pack4(32'h7FFFFFFF, 32'h7FFFFFFF, 2, 0),
                 pack4(32'h7FFFFFFF, 32'h80000001, 2, 0),
                 pack4(32'h7FFFFFFF, 32'h80000000, 4, 0));
`else
    vecs[2] = mk(1, 1, 0, pack4(32'h7FFFFFFF, 32'h7FFFFFFF, 2, 0),
                 pack4(32'h7FFFFFFF, 32'h80000001, 2, 0),
                 pack4(32'h00000001, 32'hFFFFFFFF, 4, 0));
`endif
    vecs[3] = mk(0, 2, 1, pack4(-5, 100, -1, 6), pack4(3, 3, 1, -7), pack4(-8, 150, -1, -21));
    vecs[4] = mk(1, 3, 0, pack4(1, -2, 1000, -7), pack4(-4, 5, 1000, 7),
                 pack4(-12, -30, 3000000, -147));
    // Sum reaches 2^64: only representable thanks to the guard bits.
    vecs[5] = mk(1, 4, 40, pack4(32'h80000000, 32'h80000000, 1, -1),
                 pack4(32'h80000000, 32'h7FFFFFFF, 1, 1),
                 pack4(32'h01000000, 32'hFF000000, 0, -1));

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {127'd0, busy}, 0);
    chk("rst_done", {127'd0, done}, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_dvalid", {127'd0, bus.d_valid}, 0);
    chk("rst_ddata", bus.d_data, 0);
    chk("rst_ready", {126'd0, bus.a_ready, bus.b_ready}, 0);
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      run_job(vecs[i], 1'b0, 1'b0, $sformatf("vec%0d", i));
      @(posedge clk); #1;
    end

    // Backpressure: distinct data per beat, d_ready toggling
    v = mk(0, 8, 0, '0, '0, '0);
    run_job(v, 1'b1, 1'b1, "bp");
    @(posedge clk); #1;

    // Empty job
    clear_logs();
    len = '0; accum = 1'b0; shift = '0;
    bus.a_valid = 1'b1; bus.b_valid = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("len0_done", {127'd0, done}, 1);
    chk("len0_busy", {127'd0, busy}, 0);
    chk("len0_ready", {126'd0, bus.a_ready, bus.b_ready}, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("len0_ndone", done_cyc.size(), 1);
    chk("len0_nacc", acc_cyc.size(), 0);
    chk("len0_nout", outq.size(), 0);
    chk("len0_busy2", {127'd0, busy}, 0);
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;

    // Abort at beat 2 of a 5-beat ACCUM job; B withheld first (joint handshake)
    clear_logs();
    len = 16'd5; accum = 1'b1; shift = '0;
    bus.a_data = pack4(7, 7, 7, 7);
    bus.b_data = pack4(7, 7, 7, 7);
    bus.a_valid = 1'b1; bus.b_valid = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin
      chk("joint_wait", {126'd0, bus.a_ready, bus.b_ready}, 0);
      @(posedge clk); #1;
    end
    chk("joint_cnt", cnt, 0);
    bus.b_valid = 1'b1;
    g = 0;
    while (acc_cyc.size() < 2 && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    chk("clr_reach", acc_cyc.size(), 2);
    clear = 1'b1;
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("clr_busy", {127'd0, busy}, 0);
    chk("clr_cnt", cnt, 0);
    repeat (6) @(posedge clk);
    #1;
    chk("clr_nout", outq.size(), 0);
    chk("clr_ndone", done_cyc.size(), 0);
    v = mk(1, 1, 0, pack4(2, 2, 2, 2), pack4(2, 2, 2, 2), pack4(4, 4, 4, 4));
    run_job(v, 1'b0, 1'b0, "post_clr");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
